map_row_fetcher: RTL
====================

Name: map_row_fetcher

Overview:
- Playback sequencer directly upstream of the map ROM (`map`).
- Drives the ROM's row address (index_y) and lane address (index_x) one lane per clock.
- Collects the 5 lane note states of the current row into one packed word, then steps to the next row at a fixed row rate.
- Downstream note-fall/render and hit-judge logic consume row_notes on each row_valid pulse.

Parameters:
- LANES, 5, lanes per row; map_lane runs 0..LANES-1.
- ROW_W, 7, row counter width; map_row is zero-extended to the ROM's index_y at top level.
- STATE_W, 3, width of one note state (matches the ROM's data_state).
- TICK_DIV, 5000000, clocks per row period (20 rows/s at 100 MHz); legal only if TICK_DIV >= LANES+1.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- start  input  1  one-cycle pulse; begins or restarts playback at row 0
- pause  input  1  level; freezes playback while high
- map_len  input  11  map length in rows (ROM len output)
- map_state  input  STATE_W  ROM data_state for the current map_row/map_lane
- map_row  output  ROW_W  row address to ROM
- map_lane  output  3  lane address to ROM (index_x)
- row_notes  output  LANES*STATE_W  lane i state at bits [i*STATE_W +: STATE_W]
- row_num  output  ROW_W  row index belonging to row_notes
- row_valid  output  1  one-cycle pulse when row_notes/row_num update
- playing  output  1  high in FETCH and WAIT
- done  output  1  high in DONE

Behaviour:
- **Clock and reset:** one clock (clk); reset is synchronous and active-high (rst). rst overrides everything.
- **Reset values:** state IDLE; all outputs 0; internal row, lane, tick and length registers 0.
- **FSM states:** IDLE, FETCH, WAIT, DONE.
- **Priority:** rst > start > pause > normal operation.
- **IDLE:**
  - map_row/map_lane held at 0.
  - On start: len_q <= min(map_len, 2^ROW_W); row <= 0; lane <= 0; tick <= 0.
  - Then go to FETCH, or to DONE if map_len == 0.
- **FETCH:**
  - map_row = row, map_lane = lane, both registered.
  - ROM is combinational, so map_state is captured at each edge into shadow[lane].
  - lane increments each clock 0..LANES-1.
  - On the edge capturing lane LANES-1: row_notes <= shadow with the final lane merged in; row_num <= row; row_valid <= 1; lane <= 0; state -> WAIT.
  - row is advanced at WAIT exit, not here.
- **Latency:** start sampled at edge E0 -> row_valid high between E5 and E6 (LANES clocks).
- **tick counter:**
  - Counts every unpaused cycle in FETCH and WAIT.
  - Cleared on entry to FETCH.
- **WAIT:**
  - When tick == TICK_DIV-1:
    - If row == len_q-1 -> DONE.
    - Else row <= row+1, tick <= 0 -> FETCH.
  - Consecutive row_valid pulses are exactly TICK_DIV clocks apart when unpaused.
- **row_valid:** strictly one cycle; cleared the next clock even if pause rises.
- **pause high in FETCH/WAIT:**
  - row, lane, tick, state, map_row, map_lane all hold.
  - No capture.
  - On release, the sequence resumes exactly where it stopped.
  - pause is ignored in IDLE/DONE.
- **DONE:**
  - done = 1; row_notes and row_num keep the last row.
  - start restarts as from IDLE.
- **start in FETCH/WAIT:** abort the current row (no row_valid for it); restart at row 0 next cycle. shadow need not be cleared.
- **Note-state values:** passed through unmodified, including undefined values 3..7.
- **len_q:** frozen during playback; changes to map_len mid-play are ignored.

Optional Feature:
- Macro: LOOP_PLAY_EN.
- Defined:
  - In WAIT at the last row, the block wraps to row 0 (tick <= 0, go to FETCH) instead of DONE.
  - done never asserts except when map_len == 0 at start.
- Undefined: stops in DONE after the last row, as above.

Test Plan:
- **Basic fetch:** TICK_DIV=8, map rows 0..2 = {lanes 1,0,2,0,1}, {0,0,0,0,0}, {2,2,2,2,2}, map_len=3, start at E0.
  - row_valid at E5, E13, E21.
  - row_notes = 15'o10201, 15'o00000, 15'o22222; row_num 0,1,2.
  - done=1 from E29; playing=0.
- **Address sweep:** during first FETCH, map_lane = 0,1,2,3,4 on consecutive cycles with map_row=0; then map_lane holds 0 in WAIT.
- **Pause:** pause high 10 cycles starting E2 of row 0.
  - map_lane frozen at 2.
  - row_valid delayed to E15.
  - Next row pulse 8 unpaused clocks later (E23).
- **Restart mid-row:** start at E3 during row 0 fetch -> no pulse at E5; row_valid at E8 with row_num=0.
- **Edge lengths:**
  - map_len=0 -> DONE one clock after start; no row_valid.
  - map_len=200 -> clamped to 128; last row_num=127.
- **LOOP_PLAY_EN:** map_len=2 -> row_num sequence 0,1,0,1 with 8-clock spacing; done stays 0. rst asserted mid-WAIT -> all outputs 0 next clock, state IDLE.

Source files
------------

// File: rtl/map_row_fetcher.sv
// Purpose: map ROM row sequencer; walks lanes of each row, emits one packed row per row period (LOOP_PLAY_EN: wrap to row 0 at end).
// Latency: row_valid pulses LANES clocks after start; consecutive rows exactly TICK_DIV unpaused clocks apart.
// Backpressure: none from downstream; pause level freezes all sequencing state, start aborts and restarts at row 0.
module map_row_fetcher #(
    parameter int LANES    = 5,
    parameter int ROW_W    = 7,
    parameter int STATE_W  = 3,
    parameter int TICK_DIV = 5000000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       pause,
    input  logic [10:0]                map_len,
    input  logic [STATE_W-1:0]         map_state,
    output logic [ROW_W-1:0]           map_row,
    output logic [2:0]                 map_lane,
    output logic [LANES*STATE_W-1:0]   row_notes,
    output logic [ROW_W-1:0]           row_num,
    output logic                       row_valid,
    output logic                       playing,
    output logic                       done
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
    localparam logic [2:0]        LANE_LAST = 3'(LANES - 1);
    localparam logic [2:0]        LANE_ONE  = 3'd1;
    localparam logic [ROW_W-1:0]  ROW_ONE   = ROW_W'(1);
    localparam logic [ROW_W:0]    LEN_ONE   = (ROW_W + 1)'(1);
    localparam logic [10:0]       LEN_MAX   = 11'(2 ** ROW_W);

    typedef enum logic [1:0] {IDLE, FETCH, WAIT, DONE} state_t;

    state_t                     state_q, state_d;
    logic [ROW_W-1:0]           row_q;
    logic [2:0]                 lane_q;
    logic [TICK_W-1:0]          tick_q;
    logic [ROW_W:0]             len_q;
    logic [LANES*STATE_W-1:0]   shadow_q;
    logic [LANES*STATE_W-1:0]   merged;
    logic [ROW_W:0]             len_clamp;
    logic                       last_row;

    // Control strobes decoded from the FSM for the datapath register block.
    logic load, cap, last_cap, advance, wrap, tick_inc;

    assign map_row   = row_q;
    assign map_lane  = lane_q;
    assign playing   = (state_q == FETCH) || (state_q == WAIT);
    assign done      = (state_q == DONE);
    // Map length is clamped to what the row counter can address.
    assign len_clamp = (map_len > LEN_MAX) ? LEN_MAX[ROW_W:0] : map_len[ROW_W:0];
    assign last_row  = ({1'b0, row_q} == (len_q - LEN_ONE));

    // Shadow row with the lane currently on the ROM bus folded in.
    always_comb begin
        merged = shadow_q;
        for (int i = 0; i < LANES; i++) begin
            if (lane_q == 3'(i)) begin
                merged[i*STATE_W +: STATE_W] = map_state;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath strobes; start beats pause, pause freezes FETCH/WAIT.
    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        cap      = 1'b0;
        last_cap = 1'b0;
        advance  = 1'b0;
        wrap     = 1'b0;
        tick_inc = 1'b0;
        if (start) begin
            load    = 1'b1;
            state_d = (map_len == 11'd0) ? DONE : FETCH;
        end else begin
            case (state_q)
                FETCH: begin
                    if (!pause) begin
                        cap      = 1'b1;
                        tick_inc = 1'b1;
                        if (lane_q == LANE_LAST) begin
                            last_cap = 1'b1;
                            state_d  = WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!pause) begin
                        if (tick_q == TICK_LAST) begin
                            if (last_row) begin
`ifdef LOOP_PLAY_EN
                                wrap    = 1'b1;
                                state_d = FETCH;
`else
                                state_d = DONE;
`endif
                            end else begin
                                advance = 1'b1;
                                state_d = FETCH;
                            end
                        end else begin
                            tick_inc = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Row/lane/tick counters, lane capture and row output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_q     <= '0;
            lane_q    <= '0;
            tick_q    <= '0;
            len_q     <= '0;
            shadow_q  <= '0;
            row_notes <= '0;
            row_num   <= '0;
            row_valid <= 1'b0;
        end else begin
            row_valid <= 1'b0;
            if (load) begin
                len_q  <= len_clamp;
                row_q  <= '0;
                lane_q <= '0;
                tick_q <= '0;
            end else begin
                if (cap) begin
                    shadow_q <= merged;
                    lane_q   <= last_cap ? 3'd0 : lane_q + LANE_ONE;
                end
                if (last_cap) begin
                    row_notes <= merged;
                    row_num   <= row_q;
                    row_valid <= 1'b1;
                end
                if (tick_inc) begin
                    tick_q <= tick_q + TICK_ONE;
                end
                if (advance) begin
                    row_q  <= row_q + ROW_ONE;
                    tick_q <= '0;
                end
                if (wrap) begin
                    row_q  <= '0;
                    tick_q <= '0;
                end
            end
        end
    end

endmodule
